// File: rtl/user_wb_responder.sv
// -----------------------------------------------------------------------------
// user_wb_responder
//
// Wishbone classic responder for the user-project bus of the management SoC.
// Decodes a 256-byte window and provides:
//   - eight byte-writable 32-bit scratch registers (offsets 0x00..0x1C)
//   - a mailbox FIFO (push/pop through offset 0x20)
//   - STATUS (0x24): empty, full, sticky OVF/UNF (write-1-to-clear), count
//   - CTRL   (0x28): irq_en
// Acknowledge latency is programmable through WAIT_STATES.
//
// Ports:
//   core_clk   sole clock
//   core_rstn  asynchronous active-low reset
//   wb_iena    bus enable; while low no request is accepted and ack/dat are 0
//   cyc_i      bus cycle
//   stb_i      strobe
//   we_i       write enable
//   sel_i      byte lanes
//   adr_i      byte address
//   dat_i      write data
//   ack_o      single-cycle acknowledge
//   dat_o      read data, 0 whenever ack_o is low
//   irq_o      registered irq_en & ~empty
// -----------------------------------------------------------------------------
module user_wb_responder #(
  parameter logic [31:0] BASE_ADR    = 32'h3000_0000,
  parameter logic [31:0] ADR_MASK    = 32'hFFFF_FF00,
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned FIFO_DEPTH  = 8
) (
  input  logic        core_clk,
  input  logic        core_rstn,
  input  logic        wb_iena,
  input  logic        cyc_i,
  input  logic        stb_i,
  input  logic        we_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] adr_i,
  input  logic [31:0] dat_i,
  output logic        ack_o,
  output logic [31:0] dat_o,
  output logic        irq_o
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  // Counter preload; WAIT is never entered when WAIT_STATES is 0.
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  // Word offsets inside the window
  localparam logic [5:0] OFF_FIFO   = 6'h08;
  localparam logic [5:0] OFF_STATUS = 6'h09;
  localparam logic [5:0] OFF_CTRL   = 6'h0A;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  wcnt_q, wcnt_d;

  logic        ack_q;
  logic [31:0] dat_q;
  logic        irq_q;

  logic [31:0] regs_q [8];
  logic [31:0] mem_q  [FIFO_DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q;
  logic        ovf_q, unf_q, irq_en_q;

  logic        hit_s;
  logic        req_s;
  logic        hold_s;
  logic        commit_s;
  logic [5:0]  word_s;
  logic        is_reg_s, is_fifo_s, is_status_s, is_ctrl_s;
  logic [2:0]  reg_idx_s;
  logic        wr_s, rd_s;
  logic        push_s, pop_s;
  logic        full_s, empty_s;
  logic        ovf_clr_s, unf_clr_s;
  logic [31:0] status_s;
  logic [31:0] rd_data_s;

  // Address decode and request qualification
  always_comb begin
    hit_s       = ((adr_i & ADR_MASK) == (BASE_ADR & ADR_MASK));
    hold_s      = wb_iena & cyc_i & stb_i;
    req_s       = hold_s & hit_s;
    word_s      = adr_i[7:2];
    reg_idx_s   = word_s[2:0];
    is_reg_s    = (word_s[5:3] == 3'd0);
    is_fifo_s   = (word_s == OFF_FIFO);
    is_status_s = (word_s == OFF_STATUS);
    is_ctrl_s   = (word_s == OFF_CTRL);
  end

  // FSM next-state and wait counter
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      S_IDLE: begin
        if (req_s) begin
          if (WAIT_STATES == 0) begin
            state_d = S_ACK;
          end else begin
            state_d = S_WAIT;
            wcnt_d  = WAIT_LOAD;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        // Abort takes priority: the master withdrew, nothing is committed.
        if (!hold_s) begin
          state_d = S_IDLE;
        end else if (wcnt_q == 4'd0) begin
          state_d = S_ACK;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        wcnt_d  = 4'd0;
      end
    endcase
  end

  // All side effects happen on the edge that enters ACK, using the request
  // signals presented in the cycle just before it.
  always_comb begin
    commit_s  = (state_d == S_ACK);
    wr_s      = commit_s & we_i;
    rd_s      = commit_s & ~we_i;
    push_s    = wr_s & is_fifo_s;
    pop_s     = rd_s & is_fifo_s;
    full_s    = (count_q == CW'(FIFO_DEPTH));
    empty_s   = (count_q == '0);
    ovf_clr_s = wr_s & is_status_s & sel_i[0] & dat_i[2];
    unf_clr_s = wr_s & is_status_s & sel_i[0] & dat_i[3];
  end

  // STATUS word assembly
  always_comb begin
    status_s         = 32'd0;
    status_s[0]      = empty_s;
    status_s[1]      = full_s;
    status_s[2]      = ovf_q;
    status_s[3]      = unf_q;
    status_s[8 +: CW] = count_q;
  end

  // Read data mux
  always_comb begin
    rd_data_s = 32'd0;
    if (is_reg_s) begin
      rd_data_s = regs_q[reg_idx_s];
    end else if (is_fifo_s) begin
      if (empty_s) begin
        rd_data_s = 32'd0;
      end else begin
        rd_data_s = mem_q[rptr_q];
      end
    end else if (is_status_s) begin
      rd_data_s = status_s;
    end else if (is_ctrl_s) begin
      rd_data_s = {31'd0, irq_en_q};
    end else begin
      rd_data_s = 32'd0;
    end
  end

  // FSM state and wait counter registers
  always_ff @(posedge core_clk or negedge core_rstn) begin
    if (!core_rstn) begin
      state_q <= S_IDLE;
      wcnt_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Acknowledge and read-data capture; dat_q is non-zero only in the ACK cycle
  always_ff @(posedge core_clk or negedge core_rstn) begin
    if (!core_rstn) begin
      ack_q <= 1'b0;
      dat_q <= 32'd0;
    end else begin
      ack_q <= commit_s;
      dat_q <= rd_s ? rd_data_s : 32'd0;
    end
  end

  // Scratch registers with per-lane write strobes
  always_ff @(posedge core_clk or negedge core_rstn) begin
    if (!core_rstn) begin
      for (int i = 0; i < 8; i++) begin
        regs_q[i] <= 32'd0;
      end
    end else if (wr_s && is_reg_s) begin
      for (int b = 0; b < 4; b++) begin
        if (sel_i[b]) begin
          regs_q[reg_idx_s][8*b +: 8] <= dat_i[8*b +: 8];
        end
      end
    end
  end

  // Mailbox FIFO; pointers wrap naturally since the depth is a power of two
  always_ff @(posedge core_clk or negedge core_rstn) begin
    if (!core_rstn) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_q[i] <= 32'd0;
      end
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (push_s && !full_s) begin
      mem_q[wptr_q] <= dat_i;
      wptr_q        <= wptr_q + PW'(1);
      count_q       <= count_q + CW'(1);
    end else if (pop_s && !empty_s) begin
      rptr_q  <= rptr_q + PW'(1);
      count_q <= count_q - CW'(1);
    end
  end

  // Sticky overflow/underflow flags; set and clear never coincide because
  // only one access commits per edge.
  always_ff @(posedge core_clk or negedge core_rstn) begin
    if (!core_rstn) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (push_s && full_s) begin
        ovf_q <= 1'b1;
      end else if (ovf_clr_s) begin
        ovf_q <= 1'b0;
      end
      if (pop_s && empty_s) begin
        unf_q <= 1'b1;
      end else if (unf_clr_s) begin
        unf_q <= 1'b0;
      end
    end
  end

  // CTRL register
  always_ff @(posedge core_clk or negedge core_rstn) begin
    if (!core_rstn) begin
      irq_en_q <= 1'b0;
    end else if (wr_s && is_ctrl_s) begin
      irq_en_q <= dat_i[0];
    end
  end

  // Interrupt follows the registered state one cycle later
  always_ff @(posedge core_clk or negedge core_rstn) begin
    if (!core_rstn) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_en_q & ~empty_s;
    end
  end

  // Output gating: a disabled bus sees neither ack nor data
  always_comb begin
    ack_o = ack_q & wb_iena;
    if (ack_o) begin
      dat_o = dat_q;
    end else begin
      dat_o = 32'd0;
    end
    irq_o = irq_q;
  end

endmodule

// File: tb/tb_user_wb_responder.sv
// -----------------------------------------------------------------------------
// Testbench for user_wb_responder. Two instances share the bus inputs but have
// separate enables: u_dut1 (WAIT_STATES=1) and u_dut3 (WAIT_STATES=3).
// -----------------------------------------------------------------------------
module tb_user_wb_responder;

  logic        clk;
  logic        rstn;
  logic        iena1, iena3;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, wdat;
  logic        ack1, ack3, irq1, irq3;
  logic [31:0] dat1, dat3;

  int nerr = 0;
  int nchk = 0;

  user_wb_responder #(.WAIT_STATES(1)) u_dut1 (
    .core_clk(clk), .core_rstn(rstn), .wb_iena(iena1),
    .cyc_i(cyc), .stb_i(stb), .we_i(we), .sel_i(sel), .adr_i(adr), .dat_i(wdat),
    .ack_o(ack1), .dat_o(dat1), .irq_o(irq1)
  );

  user_wb_responder #(.WAIT_STATES(3)) u_dut3 (
    .core_clk(clk), .core_rstn(rstn), .wb_iena(iena3),
    .cyc_i(cyc), .stb_i(stb), .we_i(we), .sel_i(sel), .adr_i(adr), .dat_i(wdat),
    .ack_o(ack3), .dat_o(dat3), .irq_o(irq3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] wd;
    logic        exp_ack;
    logic        chk_rd;
    logic [31:0] exp_rd;
    string       name;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic w, input logic [3:0] s, input logic [31:0] a,
                              input logic [31:0] d, input logic ea, input logic cr,
                              input logic [31:0] er, input string n);
    vec_t v;
    v.we = w; v.sel = s; v.adr = a; v.wd = d;
    v.exp_ack = ea; v.chk_rd = cr; v.exp_rd = er; v.name = n;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One bus access on the chosen instance. Starts and ends #1 after a posedge.
  // Returns after the cycle following the ack so ack/dat drop can be checked.
  task automatic bus(input logic d3, input logic w, input logic [3:0] s,
                     input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output logic got, output int lat);
    iena1 = ~d3; iena3 = d3;
    cyc = 1'b1; stb = 1'b1; we = w; sel = s; adr = a; wdat = d;
    got = 1'b0; lat = 0; rd = 32'd0;
    for (int i = 1; i <= 20 && !got; i++) begin
      @(posedge clk); #1;
      if ((d3 ? ack3 : ack1) === 1'b1) begin
        got = 1'b1;
        lat = i;
        rd  = d3 ? dat3 : dat1;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    if (got) begin
      @(posedge clk); #1;
      chk("ack_one_cycle", {31'd0, (d3 ? ack3 : ack1)}, 32'd0);
      chk("dat_zero_no_ack", (d3 ? dat3 : dat1), 32'd0);
    end
  endtask

  logic [31:0] rd;
  logic        got;
  int          lat;

  initial begin
    rstn = 1'b0; iena1 = 1'b0; iena3 = 1'b0;
    cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; adr = 32'd0; wdat = 32'd0;

    // ---------------- vector table (instance with WAIT_STATES=1) -------------
    vecs.push_back(mk(1'b0, 4'hF, 32'h3000_0000, 32'd0,          1'b1, 1'b1, 32'h0000_0000, "rst_reg0"));
    vecs.push_back(mk(1'b0, 4'hF, 32'h3000_0024, 32'd0,          1'b1, 1'b1, 32'h0000_0001, "rst_status"));
    vecs.push_back(mk(1'b0, 4'hF, 32'h3000_0028, 32'd0,          1'b1, 1'b1, 32'h0000_0000, "rst_ctrl"));
    vecs.push_back(mk(1'b1, 4'hF, 32'h3000_0004, 32'hDEAD_BEEF,  1'b1, 1'b0, 32'd0,         "wr_reg1_full"));
    vecs.push_back(mk(1'b1, 4'h1, 32'h3000_0004, 32'h0000_00AA,  1'b1, 1'b0, 32'd0,         "wr_reg1_lane0"));
    vecs.push_back(mk(1'b0, 4'hF, 32'h3000_0004, 32'd0,          1'b1, 1'b1, 32'hDEAD_BEAA, "byte_lane"));
    vecs.push_back(mk(1'b1, 4'hA, 32'h3000_0008, 32'h1122_3344,  1'b1, 1'b0, 32'd0,         "wr_reg2_lanes13"));
    vecs.push_back(mk(1'b0, 4'hF, 32'h3000_0008, 32'd0,          1'b1, 1'b1, 32'h1100_3300, "lanes_1_3"));
    vecs.push_back(mk(1'b1, 4'hF, 32'h3000_001C, 32'hCAFE_F00D,  1'b1, 1'b0, 32'd0,         "wr_reg7"));
    vecs.push_back(mk(1'b0, 4'hF, 32'h3000_001C, 32'd0,          1'b1, 1'b1, 32'hCAFE_F00D, "reg7"));
    vecs.push_back(mk(1'b1, 4'hF, 32'h3000_0028, 32'hFFFF_FFFF,  1'b1, 1'b0, 32'd0,         "wr_ctrl1"));
    vecs.push_back(mk(1'b0, 4'hF, 32'h3000_0028, 32'd0,          1'b1, 1'b1, 32'h0000_0001, "ctrl_set"));
    vecs.push_back(mk(1'b1, 4'hF, 32'h3000_0028, 32'h0000_0000,  1'b1, 1'b0, 32'd0,         "wr_ctrl0"));
    vecs.push_back(mk(1'b0, 4'hF, 32'h3000_0028, 32'd0,          1'b1, 1'b1, 32'h0000_0000, "ctrl_clr"));
    for (int i = 1; i <= 8; i++)
      vecs.push_back(mk(1'b1, 4'h0, 32'h3000_0020, 32'(i),       1'b1, 1'b0, 32'd0,         "push"));
    vecs.push_back(mk(1'b0, 4'hF, 32'h3000_0024, 32'd0,          1'b1, 1'b1, 32'h0000_0802, "status_full"));
    vecs.push_back(mk(1'b1, 4'hF, 32'h3000_0020, 32'd9,          1'b1, 1'b0, 32'd0,         "push_ovf"));
    vecs.push_back(mk(1'b0, 4'hF, 32'h3000_0024, 32'd0,          1'b1, 1'b1, 32'h0000_0806, "status_ovf"));
    for (int i = 1; i <= 8; i++)
      vecs.push_back(mk(1'b0, 4'hF, 32'h3000_0020, 32'd0,        1'b1, 1'b1, 32'(i),        "pop"));
    vecs.push_back(mk(1'b0, 4'hF, 32'h3000_0024, 32'd0,          1'b1, 1'b1, 32'h0000_0005, "status_drained"));
    vecs.push_back(mk(1'b0, 4'hF, 32'h3000_0020, 32'd0,          1'b1, 1'b1, 32'h0000_0000, "pop_empty"));
    vecs.push_back(mk(1'b0, 4'hF, 32'h3000_0024, 32'd0,          1'b1, 1'b1, 32'h0000_000D, "status_unf"));
    vecs.push_back(mk(1'b1, 4'hE, 32'h3000_0024, 32'h0000_000C,  1'b1, 1'b0, 32'd0,         "w1c_nosel0"));
    vecs.push_back(mk(1'b0, 4'hF, 32'h3000_0024, 32'd0,          1'b1, 1'b1, 32'h0000_000D, "sticky_needs_sel0"));
    vecs.push_back(mk(1'b1, 4'h1, 32'h3000_0024, 32'h0000_0000,  1'b1, 1'b0, 32'd0,         "w0_status"));
    vecs.push_back(mk(1'b0, 4'hF, 32'h3000_0024, 32'd0,          1'b1, 1'b1, 32'h0000_000D, "sticky_w0"));
    vecs.push_back(mk(1'b1, 4'hF, 32'h3000_0024, 32'h0000_000C,  1'b1, 1'b0, 32'd0,         "w1c"));
    vecs.push_back(mk(1'b0, 4'hF, 32'h3000_0024, 32'd0,          1'b1, 1'b1, 32'h0000_0001, "sticky_clr"));
    vecs.push_back(mk(1'b1, 4'hF, 32'h3000_0040, 32'h0000_1234,  1'b1, 1'b0, 32'd0,         "wr_unmapped"));
    vecs.push_back(mk(1'b0, 4'hF, 32'h3000_0040, 32'd0,          1'b1, 1'b1, 32'h0000_0000, "unmapped"));
    vecs.push_back(mk(1'b1, 4'hF, 32'h3000_0104, 32'h5555_5555,  1'b0, 1'b0, 32'd0,         "miss_wr"));
    vecs.push_back(mk(1'b0, 4'hF, 32'h3000_0100, 32'd0,          1'b0, 1'b0, 32'd0,         "miss_rd"));
    vecs.push_back(mk(1'b0, 4'hF, 32'h3000_0004, 32'd0,          1'b1, 1'b1, 32'hDEAD_BEAA, "miss_no_alias"));

    // ---------------- reset ----------------
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack1", {31'd0, ack1}, 32'd0);
    chk("rst_dat1", dat1, 32'd0);
    chk("rst_irq1", {31'd0, irq1}, 32'd0);
    chk("rst_ack3", {31'd0, ack3}, 32'd0);
    chk("rst_irq3", {31'd0, irq3}, 32'd0);
    @(negedge clk) rstn = 1'b1;
    @(posedge clk); #1;

    // ---------------- table-driven vectors ----------------
    foreach (vecs[k]) begin
      bus(1'b0, vecs[k].we, vecs[k].sel, vecs[k].adr, vecs[k].wd, rd, got, lat);
      chk({vecs[k].name, "_ack"}, {31'd0, got}, {31'd0, vecs[k].exp_ack});
      if (vecs[k].exp_ack) chk({vecs[k].name, "_lat"}, 32'(lat), 32'd2);
      if (vecs[k].chk_rd)  chk({vecs[k].name, "_rd"}, rd, vecs[k].exp_rd);
    end

    // ---------------- IRQ timing ----------------
    bus(1'b0, 1'b1, 4'hF, 32'h3000_0028, 32'd1, rd, got, lat);
    chk("irq_empty", {31'd0, irq1}, 32'd0);
    bus(1'b0, 1'b1, 4'hF, 32'h3000_0020, 32'h0000_00A5, rd, got, lat);
    chk("irq_set", {31'd0, irq1}, 32'd1);
    bus(1'b0, 1'b0, 4'hF, 32'h3000_0020, 32'd0, rd, got, lat);
    chk("irq_pop_rd", rd, 32'h0000_00A5);
    chk("irq_clr", {31'd0, irq1}, 32'd0);
    bus(1'b0, 1'b1, 4'hF, 32'h3000_0028, 32'd0, rd, got, lat);

    // ---------------- abort in WAIT (WAIT_STATES=3) ----------------
    bus(1'b1, 1'b1, 4'h0, 32'h3000_0020, 32'h0000_0055, rd, got, lat);
    chk("ws3_push_lat", 32'(lat), 32'd4);
    bus(1'b1, 1'b0, 4'hF, 32'h3000_0024, 32'd0, rd, got, lat);
    chk("ws3_status_pre", rd, 32'h0000_0100);
    iena1 = 1'b0; iena3 = 1'b1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = 32'h3000_0020;
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (ack3 === 1'b1) got = 1'b1;
      if (i == 1) begin cyc = 1'b0; stb = 1'b0; end
    end
    chk("abort_noack", {31'd0, got}, 32'd0);
    bus(1'b1, 1'b0, 4'hF, 32'h3000_0024, 32'd0, rd, got, lat);
    chk("abort_count", rd, 32'h0000_0100);

    // ---------------- wb_iena gating ----------------
    iena1 = 1'b0; iena3 = 1'b0;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; adr = 32'h3000_0000; wdat = 32'h1234_5678;
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (ack1 === 1'b1 || ack3 === 1'b1) got = 1'b1;
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    chk("iena_noack", {31'd0, got}, 32'd0);
    bus(1'b0, 1'b0, 4'hF, 32'h3000_0000, 32'd0, rd, got, lat);
    chk("iena_reg0", rd, 32'd0);

    // ---------------- reset mid-WAIT ----------------
    bus(1'b0, 1'b1, 4'hF, 32'h3000_0028, 32'd1, rd, got, lat);
    bus(1'b0, 1'b1, 4'hF, 32'h3000_0020, 32'h0000_0077, rd, got, lat);
    iena1 = 1'b1; iena3 = 1'b0;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; adr = 32'h3000_0000; wdat = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    rstn = 1'b0;
    #1;
    chk("rstwait_ack_now", {31'd0, ack1}, 32'd0);
    @(posedge clk); #1;
    chk("rstwait_ack_hold", {31'd0, ack1}, 32'd0);
    chk("rstwait_irq", {31'd0, irq1}, 32'd0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk) rstn = 1'b1;
    @(posedge clk); #1;
    bus(1'b0, 1'b0, 4'hF, 32'h3000_0000, 32'd0, rd, got, lat);
    chk("rstwait_reg0", rd, 32'd0);
    bus(1'b0, 1'b0, 4'hF, 32'h3000_0004, 32'd0, rd, got, lat);
    chk("rstwait_reg1", rd, 32'd0);
    bus(1'b0, 1'b0, 4'hF, 32'h3000_0024, 32'd0, rd, got, lat);
    chk("rstwait_status", rd, 32'h0000_0001);
    bus(1'b0, 1'b0, 4'hF, 32'h3000_0028, 32'd0, rd, got, lat);
    chk("rstwait_ctrl", rd, 32'd0);
    bus(1'b1, 1'b0, 4'hF, 32'h3000_0024, 32'd0, rd, got, lat);
    chk("rstwait_ws3_status", rd, 32'h0000_0001);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
